display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//   Time-multiplexes four 4-bit digit values onto one shared 7-seg digit bus.
//   Sits between the cleaned-switch/value logic and the seven-segment decoder.
//   Replaces derived-clock scanning: all logic runs on clk_disp.
//   Sequencing uses an internal prescaler enable, a per-digit blanking gap and
//   a frame-synchronous load handshake.
// PARAMETERS
//   PRESCALE_W    10  drive time per digit = 2**PRESCALE_W cycles
//   BLANK_CYCLES  16  all-anodes-off gap between digits; legal range >= 1
// PORTS
//   clk_disp   in   1   single clock; all flops rising-edge
//   rst_disp   in   1   synchronous, active-high reset
//   digits_in  in   16  digit d = digits_in[4*d+3:4*d]
//   load_req   in   1   level request to copy digits_in into shadow register
//   load_ack   out  1   1-cycle pulse: digits_in captured on this edge
//   digit_en   in   4   per-digit enable; 0 keeps that anode off
//   an_out     out  4   active-low anodes; one-hot-low or 4'b1111
//   nib_out    out  4   nibble for the decoder; shadow[4*scan_idx+:4]
//   scan_idx   out  2   digit currently being scanned
// BEHAVIOUR
//   Registers and outputs
//     All outputs registered.
//     Reset values (next edge with rst_disp=1):
//       state=BLANK, scan_idx=0, prescaler=0, blank_cnt=BLANK_CYCLES-1,
//       shadow=16'h0, an_out=4'b1111, nib_out=0, load_ack=0.
//     Reset mid-operation aborts everything; no ack for a pending request.
//   FSM states: BLANK, DRIVE
//     BLANK:
//       an_out=1111; blank_cnt decrements each cycle.
//       At blank_cnt==0: next state DRIVE, prescaler<=0.
//     DRIVE:
//       prescaler increments each cycle.
//       an_out[scan_idx]=~digit_en[scan_idx]; all other anodes 1.
//       nib_out=shadow[4*scan_idx+:4].
//       At prescaler==2**PRESCALE_W-1: next state BLANK,
//         blank_cnt<=BLANK_CYCLES-1, scan_idx<=scan_idx+1 (3 wraps to 0).
//   Timing
//     DRIVE lasts exactly 2**PRESCALE_W cycles; BLANK lasts exactly BLANK_CYCLES.
//     Frame = 4*(2**PRESCALE_W + BLANK_CYCLES) cycles.
//     an_out/nib_out reflect state and digit_en with 1-cycle register latency.
//     Two anodes are never low in the same cycle.
//   Load handshake (frame boundary only, no tearing)
//     Load point: state==BLANK && scan_idx==0 && blank_cnt==0 && load_req==1.
//     At the load point: shadow<=digits_in; load_ack=1 for that one cycle.
//     Requester holds digits_in stable while load_req=1.
//     load_req held high -> one load per frame.
//     load_req dropped before the load point -> no load, no ack.
//     First load point is BLANK_CYCLES cycles after reset release,
//       before digit 0 first drives.
//   Width rules
//     prescaler is PRESCALE_W bits; blank_cnt is $clog2(BLANK_CYCLES+1) bits.
//     Both wrap only as stated above.
// TESTING (sim with PRESCALE_W=3, BLANK_CYCLES=2; frame = 40 cycles)
//   1 Reset, digit_en=4'hF, no load
//     -> an_out 1111 for 2 cycles, then 1110 for 8, 1111 for 2, 1101 for 8,
//        ..., 0111 for 8, then back to 1110; nib_out=0 throughout.
//   2 digits_in=16'h4321, load_req=1 from reset
//     -> load_ack pulses at cycle 2; nib_out=1,2,3,4 during drives 0..3;
//        load_ack repeats every 40 cycles.
//   3 Change digits_in to 16'hABCD while digit 2 drives, load_req held
//     -> nib_out unchanged until the next frame; then D,C,B,A.
//   4 digit_en=4'b0101
//     -> anodes 1 and 3 stay 1 for whole frame; digit 1/3 slot timing unchanged.
//   5 Assert rst_disp for 1 cycle mid-DRIVE of digit 2
//     -> next edge: an_out=1111, scan_idx=0, shadow=0, no load_ack.
//   6 Pulse load_req for 1 cycle at a non-load point
//     -> no load_ack; shadow unchanged.

Source files
------------

// File: rtl/display_scan_controller.sv
// Scans four 4-bit digits onto one shared 7-seg bus, with a blanking gap between
// digit slots and a shadow register that is reloaded only on a frame boundary.
module display_scan_controller #(
    parameter int PRESCALE_W   = 10,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk_disp,
    input  logic        rst_disp,
    input  logic [15:0] digits_in,
    input  logic        load_req,
    output logic        load_ack,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an_out,
    output logic [3:0]  nib_out,
    output logic [1:0]  scan_idx
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0]         BLANK_LOAD = BW'(BLANK_CYCLES - 1);
    localparam logic [PRESCALE_W-1:0] PRE_MAX    = '1;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                state, state_nx;
    logic [PRESCALE_W-1:0] prescaler, prescaler_nx;
    logic [BW-1:0]         blank_cnt, blank_cnt_nx;
    logic [15:0]           shadow, shadow_nx;
    logic [1:0]            scan_idx_nx;
    logic [3:0]            an_nx, nib_nx;
    logic                  load_ack_nx;
    logic                  load_pt;

    // Loading only at the end of digit 0's blanking gap keeps a frame tear-free.
    assign load_pt = (state == BLANK) && (scan_idx == 2'd0) && (blank_cnt == '0) && load_req;

    always_comb begin
        state_nx     = state;
        prescaler_nx = prescaler;
        blank_cnt_nx = blank_cnt;
        scan_idx_nx  = scan_idx;
        shadow_nx    = shadow;
        an_nx        = 4'hF;
        nib_nx       = nib_out;
        load_ack_nx  = load_pt;

        if (load_pt)
            shadow_nx = digits_in;

        case (state)
            BLANK: begin
                if (blank_cnt == '0) begin
                    state_nx     = DRIVE;
                    prescaler_nx = '0;
                end else begin
                    blank_cnt_nx = blank_cnt - 1'b1;
                end
            end
            DRIVE: begin
                prescaler_nx        = prescaler + 1'b1;
                an_nx[scan_idx]     = ~digit_en[scan_idx];
                nib_nx              = shadow[{scan_idx, 2'b00} +: 4];
                if (prescaler == PRE_MAX) begin
                    state_nx     = BLANK;
                    blank_cnt_nx = BLANK_LOAD;
                    scan_idx_nx  = scan_idx + 1'b1;
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    always_ff @(posedge clk_disp) begin
        if (rst_disp) begin
            state     <= BLANK;
            prescaler <= '0;
            blank_cnt <= BLANK_LOAD;
            scan_idx  <= 2'd0;
            shadow    <= 16'h0;
            an_out    <= 4'hF;
            nib_out   <= 4'h0;
            load_ack  <= 1'b0;
        end else begin
            state     <= state_nx;
            prescaler <= prescaler_nx;
            blank_cnt <= blank_cnt_nx;
            scan_idx  <= scan_idx_nx;
            shadow    <= shadow_nx;
            an_out    <= an_nx;
            nib_out   <= nib_nx;
            load_ack  <= load_ack_nx;
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: fixed-cycle vector table, hand-written
// corner sequences, then random stimulus against a frame-arithmetic model.
module tb_display_scan_controller;
    localparam int D = 8;           // 2**PRESCALE_W
    localparam int B = 2;           // BLANK_CYCLES
    localparam int S = D + B;       // slot length
    localparam int F = 4 * S;       // frame length

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic        load_req = 1'b0;
    logic        load_ack;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  an_out, nib_out;
    logic [1:0]  scan_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    display_scan_controller #(.PRESCALE_W(3), .BLANK_CYCLES(2)) dut (
        .clk_disp (clk),
        .rst_disp (rst),
        .digits_in(digits_in),
        .load_req (load_req),
        .load_ack (load_ack),
        .digit_en (digit_en),
        .an_out   (an_out),
        .nib_out  (nib_out),
        .scan_idx (scan_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic        ld;
        logic [15:0] dig;
        int          at;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        ack;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_all(input string tag, input logic [3:0] an, input logic [3:0] nib,
                           input logic ack, input logic [1:0] idx);
        chk({tag, ".an"},  32'(an_out),   32'(an));
        chk({tag, ".nib"}, 32'(nib_out),  32'(nib));
        chk({tag, ".ack"}, 32'(load_ack), 32'(ack));
        chk({tag, ".idx"}, 32'(scan_idx), 32'(idx));
    endtask

    // Reference model state: edges since reset, shadow contents, held nibble.
    int          mc;
    logic [15:0] mshadow;
    logic [3:0]  mnib;

    initial begin
        logic [3:0] e_an;
        logic       e_ack;
        int qp, sp;

        // Vector table: {en, load_req, digits, cycle, an, nib, ack, idx}
        vecs.push_back('{4'hF, 1'b1, 16'h4321,  1, 4'hF, 4'h0, 1'b0, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 16'h4321,  2, 4'hF, 4'h0, 1'b1, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 16'h4321,  3, 4'hE, 4'h1, 1'b0, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 10, 4'hE, 4'h1, 1'b0, 2'd1});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 11, 4'hF, 4'h1, 1'b0, 2'd1});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 13, 4'hD, 4'h2, 1'b0, 2'd1});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 33, 4'h7, 4'h4, 1'b0, 2'd3});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 42, 4'hF, 4'h4, 1'b1, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 16'h4321, 43, 4'hE, 4'h1, 1'b0, 2'd0});
        vecs.push_back('{4'h5, 1'b0, 16'h4321,  3, 4'hE, 4'h0, 1'b0, 2'd0});
        vecs.push_back('{4'h5, 1'b0, 16'h4321, 13, 4'hF, 4'h0, 1'b0, 2'd1});
        vecs.push_back('{4'h5, 1'b0, 16'h4321, 23, 4'hB, 4'h0, 1'b0, 2'd2});
        vecs.push_back('{4'hF, 1'b0, 16'h4321,  2, 4'hF, 4'h0, 1'b0, 2'd0});
        vecs.push_back('{4'hF, 1'b0, 16'h4321,  3, 4'hE, 4'h0, 1'b0, 2'd0});

        digit_en = 4'hF;
        do_reset();
        chk_all("reset", 4'hF, 4'h0, 1'b0, 2'd0);

        foreach (vecs[i]) begin
            digit_en  = vecs[i].en;
            load_req  = vecs[i].ld;
            digits_in = vecs[i].dig;
            do_reset();
            go_to(vecs[i].at);
            chk_all($sformatf("vec%0d", i), vecs[i].an, vecs[i].nib, vecs[i].ack, vecs[i].idx);
        end

        // Digits change mid-frame: shown only after the next frame load.
        digit_en = 4'hF; load_req = 1'b1; digits_in = 16'h4321;
        do_reset();
        go_to(25);
        digits_in = 16'hABCD;
        go_to(30); chk("tear.d2", 32'(nib_out), 32'h3);
        go_to(33); chk("tear.d3", 32'(nib_out), 32'h4);
        go_to(42); chk("tear.ack", 32'(load_ack), 32'h1);
        go_to(43); chk("tear.new0", 32'(nib_out), 32'hD);
        go_to(53); chk("tear.new1", 32'(nib_out), 32'hC);

        // Reset during digit 2 drive clears everything, including shadow.
        go_to(65);
        load_req = 1'b0;
        do_reset();
        chk_all("midrst", 4'hF, 4'h0, 1'b0, 2'd0);
        go_to(2);  chk("midrst.noack", 32'(load_ack), 32'h0);
        go_to(3);  chk("midrst.shadow", 32'(nib_out), 32'h0);

        // Single-cycle request away from the load point is ignored.
        digits_in = 16'h9876;
        go_to(10);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("pulse.noack", 32'(load_ack), 32'h0);
        go_to(42); chk("pulse.noack2", 32'(load_ack), 32'h0);
        go_to(43); chk("pulse.shadow", 32'(nib_out), 32'h0);

        // Random phase against a frame-position model.
        mc = 0; mshadow = '0; mnib = '0;
        for (int i = 0; i < 3000; i++) begin
            rst      = (i == 0) || ($urandom_range(0, 299) == 0);
            digit_en = 4'($urandom);
            load_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) digits_in = 16'($urandom);

            if (rst) begin
                mc = 0; mshadow = '0; mnib = '0;
                e_an = 4'hF; e_ack = 1'b0;
            end else begin
                qp = mc % F;
                sp = qp / S;
                e_an  = 4'hF;
                e_ack = (qp == B - 1) && load_req;
                if ((qp % S) >= B) begin
                    e_an[sp] = ~digit_en[sp];
                    mnib     = mshadow[4*sp +: 4];
                end
                if (e_ack) mshadow = digits_in;
                mc++;
            end
            step();
            chk("rnd.an",  32'(an_out),   32'(e_an));
            chk("rnd.nib", 32'(nib_out),  32'(mnib));
            chk("rnd.ack", 32'(load_ack), 32'(e_ack));
            chk("rnd.idx", 32'(scan_idx), 32'((mc % F) / S));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
